mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 39 +++
 rtl/mem_stage_align.sv | 43 ++++
 rtl/mem_stage.sv | 187 ++++++++++++++++++
 tb/tb_mem_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM states, load/store func3 codes,
// byte-enable patterns and an access-size decode helper.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;
    localparam logic [2:0] F_SB  = 3'b000;
    localparam logic [2:0] F_SH  = 3'b001;
    localparam logic [2:0] F_SW  = 3'b010;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // func3[1:0] carries the size for both loads and stores; func3[2] marks unsigned loads
    function automatic size_t size_of(input logic [2:0] func);
        case (func[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// mem_align: combinational lane logic -- byte enables, write-data replication
// and read-data extraction with sign/zero extension. Halves/words are always lane-aligned.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  func,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata_raw,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        be        = BE_WORD;
        wdata     = wdata_raw;
        rdata     = rdata_raw;
        byte_lane = rdata_raw[{addr_lo, 3'b000} +: 8];
        half_lane = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
        case (size_of(func))
            SZ_BYTE: begin
                be    = BE_BYTE << addr_lo;
                wdata = {4{wdata_raw[7:0]}};
                rdata = func[2] ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            end
            SZ_HALF: begin
                be    = BE_HALF << {addr_lo[1], 1'b0};
                wdata = {2{wdata_raw[15:0]}};
                rdata = func[2] ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
            end
            default: begin
                be    = BE_WORD;
                wdata = wdata_raw;
                rdata = rdata_raw;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: data-bus access sequencing with timeout and MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_STAGE_MISALIGN_TRAP_EN.
//   state  | meaning
//   IDLE   | pass ALU results to write-back; accept a new load/store
//   ACCESS | bus request outstanding from latched request; stall upstream
//   DONE   | one-cycle write-back of load data / store completion / error
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] result,
    input  logic [31:0] data_for_writing_for_sw,
    input  logic        mem_read_mem,
    input  logic        mem_write_mem,
    input  logic        wb_enable_mem,
    input  logic [4:0]  rd_mem,
    input  logic        ld_mem,
    input  logic [2:0]  func,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic [31:0] wb_data,
    output logic [4:0]  rd_wb,
    output logic        wb_enable_wb,
    output logic        wb_fwd_en,
    output logic [4:0]  rd_wb_fwd,
    output logic        bus_err,
    output logic        misalign
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_nxt;
    logic [31:0]   addr_q, wdata_q;
    logic [2:0]    func_q;
    logic [4:0]    rd_q;
    logic          wb_en_q, we_q, re_q;
    logic [CW-1:0] cnt;
    logic          is_mem, trap, access_ack, timeout;
    logic [3:0]    al_be;
    logic [31:0]   al_wdata, al_rdata;
    logic          unused_ld;

    // ld_mem is redundant with mem_read_mem: a load without mem_read is a plain ALU op
    assign unused_ld = ld_mem;
    assign is_mem    = mem_read_mem | mem_write_mem;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign trap = is_mem &&
                  (((size_of(func) == SZ_HALF) && result[0]) ||
                   ((size_of(func) == SZ_WORD) && (result[1:0] != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    mem_align u_align (
        .func      (func_q),
        .addr_lo   (addr_q[1:0]),
        .wdata_raw (wdata_q),
        .rdata_raw (dmem_rdata),
        .be        (al_be),
        .wdata     (al_wdata),
        .rdata     (al_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        access_ack = 1'b0;
        timeout    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 32'b0;
        dmem_wdata = 32'b0;
        dmem_be    = 4'b0;
        mem_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (is_mem) state_nxt = trap ? DONE : ACCESS;
            end
            ACCESS: begin
                dmem_req   = 1'b1;
                dmem_we    = we_q;
                dmem_addr  = {addr_q[31:2], 2'b00};
                dmem_wdata = al_wdata;
                dmem_be    = al_be;
                mem_stall  = 1'b1;
                if (dmem_ack) begin
                    access_ack = 1'b1;
                    state_nxt  = DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state != ACCESS) begin
            cnt <= '0;
        end else if (!dmem_ack) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            func_q  <= '0;
            rd_q    <= '0;
            wb_en_q <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
        end else if (state == IDLE && is_mem) begin
            addr_q  <= result;
            wdata_q <= data_for_writing_for_sw;
            func_q  <= func;
            rd_q    <= rd_mem;
            wb_en_q <= wb_enable_mem;
            we_q    <= mem_write_mem;
            re_q    <= mem_read_mem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data      <= '0;
            rd_wb        <= '0;
            wb_enable_wb <= 1'b0;
            bus_err      <= 1'b0;
            misalign     <= 1'b0;
        end else begin
            bus_err  <= 1'b0;
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    rd_wb <= rd_mem;
                    if (is_mem) begin
                        wb_data      <= '0;
                        wb_enable_wb <= 1'b0;
                        misalign     <= trap;
                    end else begin
                        wb_data      <= result;
                        wb_enable_wb <= wb_enable_mem;
                    end
                end
                ACCESS: begin
                    if (access_ack) begin
                        wb_data      <= re_q ? al_rdata : 32'b0;
                        rd_wb        <= rd_q;
                        wb_enable_wb <= wb_en_q & re_q;
                    end else if (timeout) begin
                        wb_data      <= '0;
                        rd_wb        <= rd_q;
                        wb_enable_wb <= 1'b0;
                        bus_err      <= 1'b1;
                    end
                end
                DONE:    wb_enable_wb <= 1'b0;
                default: wb_enable_wb <= 1'b0;
            endcase
        end
    end

    assign wb_fwd_en = wb_enable_wb;
    assign rd_wb_fwd = rd_wb;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed corner cases plus randomized
// ALU/load/store traffic against an arithmetic reference model.
module tb_mem_stage;
    localparam int TO = 16;

    logic        clk, rst_n;
    logic [31:0] result, data_for_writing_for_sw;
    logic        mem_read_mem, mem_write_mem, wb_enable_mem, ld_mem;
    logic [4:0]  rd_mem;
    logic [2:0]  func;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        mem_stall, wb_enable_wb, wb_fwd_en, bus_err, misalign;
    logic [31:0] wb_data;
    logic [4:0]  rd_wb, rd_wb_fwd;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .result(result),
        .data_for_writing_for_sw(data_for_writing_for_sw),
        .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
        .wb_enable_mem(wb_enable_mem), .rd_mem(rd_mem), .ld_mem(ld_mem), .func(func),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .mem_stall(mem_stall), .wb_data(wb_data), .rd_wb(rd_wb),
        .wb_enable_wb(wb_enable_wb), .wb_fwd_en(wb_fwd_en), .rd_wb_fwd(rd_wb_fwd),
        .bus_err(bus_err), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] r);
        logic [31:0] v;
        int sh;
        case (f[1:0])
            2'b00: begin
                sh = int'(a[1:0]) * 8;
                v  = (r >> sh) & 32'h0000_00FF;
                if (!f[2] && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'b01: begin
                sh = a[1] ? 16 : 0;
                v  = (r >> sh) & 32'h0000_FFFF;
                if (!f[2] && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = r;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f, input logic [31:0] a);
        logic [3:0] b;
        case (f[1:0])
            2'b00:   b = 4'b0001 << a[1:0];
            2'b01:   b = a[1] ? 4'b1100 : 4'b0011;
            default: b = 4'b1111;
        endcase
        return b;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] f, input logic [31:0] d);
        logic [31:0] w;
        case (f[1:0])
            2'b00:   w = {24'b0, d[7:0]} * 32'h0101_0101;
            2'b01:   w = {16'b0, d[15:0]} * 32'h0001_0001;
            default: w = d;
        endcase
        return w;
    endfunction

    task automatic clear_in();
        result = '0; data_for_writing_for_sw = '0; mem_read_mem = 1'b0;
        mem_write_mem = 1'b0; wb_enable_mem = 1'b0; rd_mem = '0; ld_mem = 1'b0; func = '0;
    endtask

    // Called at a negedge with the stage in IDLE; returns at a negedge in IDLE.
    task automatic alu_op(input logic [31:0] r, input logic [4:0] rd, input bit wben, input bit ld);
        result = r; rd_mem = rd; wb_enable_mem = wben; ld_mem = ld;
        mem_read_mem = 1'b0; mem_write_mem = 1'b0;
        data_for_writing_for_sw = $urandom; func = 3'($urandom_range(0, 7));
        @(posedge clk); @(negedge clk);
        chk("alu_wb_data", wb_data, r);
        chk("alu_rd_wb", 32'(rd_wb), 32'(rd));
        chk("alu_wb_en", 32'(wb_enable_wb), 32'(wben));
        chk("alu_fwd", 32'({wb_fwd_en, rd_wb_fwd}), 32'({wben, rd}));
        chk("alu_stall_req", 32'({mem_stall, dmem_req}), 32'd0);
        clear_in();
    endtask

    task automatic mem_op(input bit wr, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] rd, input bit wben,
                          input int dly, input logic [31:0] rdv);
        int n_stall = 0;
        bit to = (dly >= TO);
        logic [31:0] exp_data;
        result = a; data_for_writing_for_sw = d; func = f; rd_mem = rd;
        wb_enable_mem = wben; mem_read_mem = !wr; mem_write_mem = wr; ld_mem = !wr;
        @(posedge clk); @(negedge clk);
        // EX zeroes its outputs during a stall; drive noise anyway, it must be ignored
        clear_in();
        result = $urandom; data_for_writing_for_sw = $urandom;
        chk("acc_addr", dmem_addr, {a[31:2], 2'b00});
        chk("acc_be", 32'(dmem_be), 32'(exp_be(f, a)));
        chk("acc_we", 32'(dmem_we), 32'(wr));
        if (wr) chk("acc_wdata", dmem_wdata, exp_wd(f, d));
        while ((mem_stall || dmem_req) && n_stall < TO + 4) begin
            n_stall++;
            if (n_stall - 1 == dly) begin
                dmem_ack = 1'b1;
                dmem_rdata = rdv;
            end
            @(posedge clk); @(negedge clk);
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
        end
        clear_in();
        chk("stall_cycles", 32'(n_stall), to ? 32'(TO) : 32'(dly + 1));
        chk("done_req", 32'({dmem_req, mem_stall}), 32'd0);
        chk("done_bus_err", 32'(bus_err), 32'(to));
        chk("done_misalign", 32'(misalign), 32'd0);
        if (to) begin
            chk("to_wb_en", 32'(wb_enable_wb), 32'd0);
        end else begin
            exp_data = wr ? 32'd0 : exp_load(f, a, rdv);
            chk("done_wb_data", wb_data, exp_data);
            chk("done_wb_en", 32'(wb_enable_wb), 32'(wben && !wr));
            chk("done_rd_wb", 32'(rd_wb), 32'(rd));
            chk("done_fwd", 32'({wb_fwd_en, rd_wb_fwd}), 32'({wben && !wr, rd}));
        end
        @(posedge clk); @(negedge clk);
        chk("err_pulse_end", 32'({bus_err, dmem_req}), 32'd0);
    endtask

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    task automatic trap_op(input logic [2:0] f, input logic [31:0] a);
        result = a; func = f; rd_mem = 5'd9; wb_enable_mem = 1'b1;
        mem_read_mem = 1'b1; ld_mem = 1'b1;
        @(posedge clk); @(negedge clk);
        clear_in();
        chk("trap_req", 32'({dmem_req, mem_stall}), 32'd0);
        chk("trap_misalign", 32'(misalign), 32'd1);
        chk("trap_wb_en", 32'(wb_enable_wb), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("trap_pulse_end", 32'({misalign, dmem_req}), 32'd0);
    endtask
`endif

    initial begin
        logic [2:0] lf [5];
        logic [2:0] f;
        logic [31:0] a;
        int k, dly;
        lf = '{F_LB_C, F_LH_C, F_LW_C, F_LBU_C, F_LHU_C};
        rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        clear_in();
        #12;
        chk("rst_outs", {dmem_req, dmem_we, mem_stall, wb_enable_wb, wb_fwd_en, bus_err, misalign},
            32'd0);
        chk("rst_data", dmem_addr | dmem_wdata | wb_data | 32'(dmem_be) | 32'(rd_wb), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // first edge after release accepts the load; ack in first ACCESS cycle
        mem_op(1'b0, 3'b010, 32'h0000_0100, 32'd0, 5'd1, 1'b1, 0, 32'hDEAD_BEEF);
        mem_op(1'b0, 3'b000, 32'h0000_0103, 32'd0, 5'd2, 1'b1, 1, 32'h8011_2233);
        mem_op(1'b0, 3'b100, 32'h0000_0103, 32'd0, 5'd2, 1'b1, 2, 32'h8011_2233);
        mem_op(1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 5'd3, 1'b1, 0, 32'd0);
        mem_op(1'b0, 3'b010, 32'h0000_0200, 32'd0, 5'd4, 1'b1, 99, 32'd0);
        mem_op(1'b0, 3'b001, 32'h0000_0302, 32'd0, 5'd5, 1'b1, TO - 1, 32'h8765_4321);
        alu_op(32'h1234_5678, 5'd6, 1'b1, 1'b1);
        alu_op(32'hCAFE_0000, 5'd7, 1'b0, 1'b0);

        // reset in the second ACCESS cycle
        result = 32'h0000_0400; func = 3'b010; rd_mem = 5'd8; wb_enable_mem = 1'b1;
        mem_read_mem = 1'b1; ld_mem = 1'b1;
        @(posedge clk); @(negedge clk);
        clear_in();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_outs", {dmem_req, dmem_we, mem_stall, wb_enable_wb, bus_err}, 32'd0);
        chk("arst_data", dmem_addr | wb_data | 32'(dmem_be) | 32'(rd_wb), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("arst_no_resume", 32'({dmem_req, mem_stall, wb_enable_wb}), 32'd0);
        alu_op(32'h0000_0005, 5'd10, 1'b1, 1'b0);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        trap_op(3'b010, 32'h0000_0101);
        trap_op(3'b001, 32'h0000_0203);
`endif

        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 2);
            a = $urandom;
            dly = $urandom_range(0, 9);
            dly = (dly == 9) ? 99 : dly % 4;
            if (k == 0) begin
                alu_op($urandom, 5'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                f = (k == 1) ? lf[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                if (f[1:0] == 2'b01) a[0] = 1'b0;
                if (f[1:0] == 2'b10) a[1:0] = 2'b00;
`endif
                mem_op(k == 2, f, a, $urandom, 5'($urandom), 1'($urandom), dly, $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    localparam logic [2:0] F_LB_C  = 3'b000;
    localparam logic [2:0] F_LH_C  = 3'b001;
    localparam logic [2:0] F_LW_C  = 3'b010;
    localparam logic [2:0] F_LBU_C = 3'b100;
    localparam logic [2:0] F_LHU_C = 3'b101;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
